// File: rtl/riscv_data_ram.sv
// riscv_data_ram
//   Single-ported RV32I data memory with byte/halfword/word access, load
//   sign/zero extension, misalignment and illegal-width rejection, and a
//   sticky fault record.
//
// Ports
//   clk          in   single clock, all state updates on its rising edge
//   rst          in   asynchronous, active-high reset of the output/fault state
//   mem_req      in   request valid this cycle
//   mem_write    in   1 = store, 0 = load (qualified by mem_req)
//   mem_funct3   in   RV32I width code: 0 B, 1 H, 2 W, 4 BU, 5 HU
//   mem_addr     in   byte address (wraps modulo 4*DEPTH)
//   mem_data     in   store data, right-aligned
//   mem_read     out  load result, extended; held until the next load completes
//   mem_rvalid   out  one-cycle pulse: mem_read was updated by a load
//   mem_fault    out  one-cycle pulse: the previous request was rejected
//   fault_addr   out  address of the first rejected request since reset
//   fault_count  out  rejected requests since reset, saturating at 255
//
// Handshake: there is no ready. Every cycle with mem_req=1 is a transaction
// accepted at that rising edge. Stores commit at that edge; loads and faults
// report in the following cycle through one-cycle pulses on mem_rvalid /
// mem_fault. A faulting load pulses both, with mem_read forced to zero.

module riscv_data_ram #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_req,
    input  logic            mem_write,
    input  logic [2:0]      mem_funct3,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_data,
    output logic [XLEN-1:0] mem_read,
    output logic            mem_rvalid,
    output logic            mem_fault,
    output logic [XLEN-1:0] fault_addr,
    output logic [7:0]      fault_count
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // Contents are deliberately not reset.
    logic [XLEN-1:0] mem [DEPTH];

    logic [AW-1:0]   idx;
    logic [1:0]      off;
    logic            illegal;
    logic            misaligned;
    logic            bad;
    logic            do_store;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] word;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] load_val;

    // Upper address bits are dropped, so addresses alias modulo 4*DEPTH.
    assign idx = mem_addr[AW+1:2];
    assign off = mem_addr[1:0];

    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        case (mem_funct3)
            F3_B, F3_BU: misaligned = 1'b0;
            F3_H, F3_HU: misaligned = off[0];
            F3_W:        misaligned = (off != 2'b00);
            default:     illegal    = 1'b1;
        endcase
        bad      = illegal | misaligned;
        do_store = mem_req & mem_write & ~bad;
    end

    // Store lane enables and lane-replicated data; the enables pick which
    // copy lands. Width comes from funct3[1:0] (B/H/W).
    always_comb begin
        be    = 4'b0000;
        wdata = mem_data;
        case (mem_funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << off;
                wdata = {4{mem_data[7:0]}};
            end
            2'b01: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{mem_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = mem_data;
            end
        endcase
    end

    // Load extraction from the currently stored word. A store accepted on
    // the previous edge is already visible here.
    always_comb begin
        word     = mem[idx];
        byte_sel = word[7:0];
        case (off)
            2'b00:   byte_sel = word[7:0];
            2'b01:   byte_sel = word[15:8];
            2'b10:   byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = off[1] ? word[31:16] : word[15:0];
        case (mem_funct3)
            F3_B:    load_val = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_BU:   load_val = {{(XLEN-8){1'b0}}, byte_sel};
            F3_H:    load_val = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_HU:   load_val = {{(XLEN-16){1'b0}}, half_sel};
            default: load_val = word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_store) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Output and fault state. Reset clears it asynchronously, which also
    // kills the rvalid pulse of a load that was in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_read    <= '0;
            mem_rvalid  <= 1'b0;
            mem_fault   <= 1'b0;
            fault_addr  <= '0;
            fault_count <= 8'd0;
        end else begin
            mem_rvalid <= mem_req & ~mem_write;
            mem_fault  <= mem_req & bad;
            if (mem_req && !mem_write) begin
                mem_read <= bad ? '0 : load_val;
            end
            if (mem_req && bad) begin
                if (fault_count == 8'd0) begin
                    fault_addr <= mem_addr;
                end
                if (fault_count != 8'hFF) begin
                    fault_count <= fault_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_data_ram.sv
// Testbench for riscv_data_ram: byte-array reference model feeding an
// expected-result queue, popped one cycle after each accepted edge.
module tb_riscv_data_ram;

  localparam int DEPTH = 256;
  localparam int W = 74; // {rvalid, fault, read[31:0], count[7:0], faddr[31:0]}
  localparam logic [31:0] ADDR_MASK = 32'(4*DEPTH - 1);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  mem_funct3 = 3'd0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_data = 32'd0;
  logic [31:0] mem_read;
  logic        mem_rvalid;
  logic        mem_fault;
  logic [31:0] fault_addr;
  logic [7:0]  fault_count;

  riscv_data_ram #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .mem_req(mem_req),
    .mem_write(mem_write),
    .mem_funct3(mem_funct3),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .mem_read(mem_read),
    .mem_rvalid(mem_rvalid),
    .mem_fault(mem_fault),
    .fault_addr(fault_addr),
    .fault_count(fault_count)
  );

  // clock / reset
  initial forever #5 clk = ~clk;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail = 0;

  // reference model
  logic [7:0]  mdl [0:4*DEPTH-1];
  logic [31:0] m_read = 32'd0;
  logic [7:0]  m_cnt = 8'd0;
  logic [31:0] m_faddr = 32'd0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // driver: presents one cycle of stimulus at the falling edge and pushes
  // what the DUT must show after the next rising edge
  task automatic drive(input logic req, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data);
    int a;
    int base;
    logic bad;
    logic e_rv;
    logic e_f;
    logic [7:0] b;
    logic [15:0] h;
    @(negedge clk);
    mem_req = req;
    mem_write = wr;
    mem_funct3 = f3;
    mem_addr = addr;
    mem_data = data;
    a = int'(addr & ADDR_MASK);
    base = a & ~3;
    bad = (f3 == 3'd3) || (f3 >= 3'd6) ||
          (((f3 == 3'd1) || (f3 == 3'd5)) && addr[0]) ||
          ((f3 == 3'd2) && (addr[1:0] != 2'b00));
    e_rv = 1'b0;
    e_f = 1'b0;
    if (req) begin
      if (bad) begin
        e_f = 1'b1;
        if (m_cnt == 8'd0) m_faddr = addr;
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        if (!wr) begin
          e_rv = 1'b1;
          m_read = 32'd0;
        end
      end else if (wr) begin
        case (f3)
          3'd0: mdl[a] = data[7:0];
          3'd1: begin
            mdl[a] = data[7:0];
            mdl[a+1] = data[15:8];
          end
          default: begin
            mdl[base] = data[7:0];
            mdl[base+1] = data[15:8];
            mdl[base+2] = data[23:16];
            mdl[base+3] = data[31:24];
          end
        endcase
      end else begin
        e_rv = 1'b1;
        b = mdl[a];
        h = {mdl[base + (a & 2) + 1], mdl[base + (a & 2)]};
        case (f3)
          3'd0: m_read = {{24{b[7]}}, b};
          3'd4: m_read = {24'd0, b};
          3'd1: m_read = {{16{h[15]}}, h};
          3'd5: m_read = {16'd0, h};
          default: m_read = {mdl[base+3], mdl[base+2], mdl[base+1], mdl[base]};
        endcase
      end
    end
    exp_q.push_back({e_rv, e_f, m_read, m_cnt, m_faddr});
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
  endtask

  // monitor: compares just after each rising edge
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rvalid", {31'd0, mem_rvalid}, {31'd0, e[73]});
        check("fault", {31'd0, mem_fault}, {31'd0, e[72]});
        check("read", mem_read, e[71:40]);
        check("count", {24'd0, fault_count}, {24'd0, e[39:32]});
        check("faddr", fault_addr, e[31:0]);
      end
    end
  end

  initial begin
    logic [2:0] wr_codes [5];
    logic       r_req;
    logic       r_wr;
    logic [2:0] r_f3;
    wr_codes[0] = 3'd0;
    wr_codes[1] = 3'd1;
    wr_codes[2] = 3'd2;
    wr_codes[3] = 3'd3;
    wr_codes[4] = 3'd7;

    // reset state
    #1 rst = 1'b1;
    #2;
    check("rst_read", mem_read, 32'd0);
    check("rst_rvalid", {31'd0, mem_rvalid}, 32'd0);
    check("rst_fault", {31'd0, mem_fault}, 32'd0);
    check("rst_faddr", fault_addr, 32'd0);
    check("rst_count", {24'd0, fault_count}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // store word then load it back
    drive(1'b1, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    drive(1'b1, 1'b0, 3'd2, 32'h10, 32'd0);
    idle();
    check("sw_lw", mem_read, 32'hDEADBEEF);

    // byte store, then sub-word loads
    drive(1'b1, 1'b1, 3'd0, 32'h13, 32'h55);
    drive(1'b1, 1'b0, 3'd0, 32'h12, 32'd0);
    idle();
    check("lb", mem_read, 32'hFFFFFFAD);
    drive(1'b1, 1'b0, 3'd4, 32'h12, 32'd0);
    idle();
    check("lbu", mem_read, 32'h000000AD);
    drive(1'b1, 1'b0, 3'd1, 32'h12, 32'd0);
    idle();
    check("lh", mem_read, 32'h000055AD);
    drive(1'b1, 1'b0, 3'd2, 32'h10, 32'd0);
    idle();
    check("lw_merged", mem_read, 32'h55ADBEEF);

    // faults
    drive(1'b1, 1'b1, 3'd2, 32'h20, 32'hCAFEF00D);
    drive(1'b1, 1'b0, 3'd2, 32'h11, 32'd0);
    idle();
    check("fault_lw_read", mem_read, 32'd0);
    drive(1'b1, 1'b1, 3'd1, 32'h21, 32'h1234);
    drive(1'b1, 1'b0, 3'd3, 32'h40, 32'd0);
    idle();
    check("fault_cnt3", {24'd0, fault_count}, 32'd3);
    check("fault_addr", fault_addr, 32'h11);
    drive(1'b1, 1'b0, 3'd2, 32'h20, 32'd0);
    idle();
    check("sh_nowrite", mem_read, 32'hCAFEF00D);

    // address wrap
    drive(1'b1, 1'b1, 3'd2, 32'h0, 32'h12345678);
    drive(1'b1, 1'b0, 3'd2, 32'(4*DEPTH), 32'd0);
    idle();
    check("wrap", mem_read, 32'h12345678);

    // saturation
    for (int i = 0; i < 256; i++) drive(1'b1, 1'b0, 3'd7, 32'h80 + 32'(i), 32'd0);
    idle();
    check("sat_count", {24'd0, fault_count}, 32'd255);
    check("sat_faddr", fault_addr, 32'h11);

    // asynchronous reset with a load in flight
    @(negedge clk);
    mem_req = 1'b1;
    mem_write = 1'b0;
    mem_funct3 = 3'd2;
    mem_addr = 32'h0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_read", mem_read, 32'd0);
    check("arst_rvalid", {31'd0, mem_rvalid}, 32'd0);
    check("arst_count", {24'd0, fault_count}, 32'd0);
    check("arst_faddr", fault_addr, 32'd0);
    mem_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_read = 32'd0;
    m_cnt = 8'd0;
    m_faddr = 32'd0;
    repeat (3) idle();
    drive(1'b1, 1'b0, 3'd2, 32'h0, 32'd0);
    idle();
    check("post_rst_lw0", mem_read, 32'h12345678);
    drive(1'b1, 1'b0, 3'd2, 32'h10, 32'd0);
    idle();
    check("post_rst_lw10", mem_read, 32'h55ADBEEF);

    // random mix over the first 16 words, with aliasing upper bits
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 3'd2, 32'(4*i), $urandom());
    for (int i = 0; i < 300; i++) begin
      r_req = ($urandom_range(0, 3) != 0);
      r_wr = 1'($urandom_range(0, 1));
      r_f3 = r_wr ? wr_codes[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
      drive(r_req, r_wr, r_f3, ($urandom() & 32'hFFFF_FC00) | 32'($urandom_range(0, 63)), $urandom());
    end
    idle();
    idle();
    repeat (2) @(posedge clk);
    #2;
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
